// File: rtl/bmu_result_buffer_if.sv
// bmu_result_buffer_if: issue, BMU result and writeback signal bundle for the BMU result buffer
interface bmu_result_buffer_if #(
   parameter int DEPTH     = 4,
   parameter int TAG_WIDTH = 6
);
   typedef logic [31:0] data_word_t;
   logic                   issue_valid_i;
   logic [TAG_WIDTH-1:0]   issue_tag_i;
   logic                   issue_ready_o;
   data_word_t             bmu_result_i;
   logic                   bmu_valid_i;
   logic                   flush_i;
   data_word_t             wb_result_o;
   logic [TAG_WIDTH-1:0]   wb_tag_o;
   logic                   wb_valid_o;
   logic                   wb_ready_i;
   logic [$clog2(DEPTH):0] count_o;
   logic                   error_o;
   modport master (
      output issue_valid_i, issue_tag_i, bmu_result_i, bmu_valid_i, flush_i, wb_ready_i,
      input  issue_ready_o, wb_result_o, wb_tag_o, wb_valid_o, count_o, error_o
   );
   modport slave (
      input  issue_valid_i, issue_tag_i, bmu_result_i, bmu_valid_i, flush_i, wb_ready_i,
      output issue_ready_o, wb_result_o, wb_tag_o, wb_valid_o, count_o, error_o
   );
endinterface

// File: rtl/bmu_result_buffer.sv
// bmu_result_buffer: tags 1-cycle BMU results with their issue tag and queues them FWFT for writeback
module bmu_result_buffer #(
   parameter int DEPTH     = 4,
   parameter int TAG_WIDTH = 6
) (
   input logic                clk_i,
   input logic                rst_n_i,
   bmu_result_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);
   logic [31:0]          res_mem [DEPTH];
   logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
   logic [AW-1:0]        rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]        count_q;
   logic [TAG_WIDTH-1:0] tag_q;
   logic                 pending_q, error_q;
   logic                 ready, accept, pop, push_req, push, spurious, overflow;
   // handshake decode; ready reserves a slot for the in-flight op so a push can never overflow
   always_comb begin
      ready    = ({1'b0, count_q} + {{CW{1'b0}}, pending_q}) < LIMIT;
      accept   = bus.issue_valid_i && ready;
      pop      = (count_q != '0) && bus.wb_ready_i;
      push_req = bus.bmu_valid_i && pending_q;
      push     = push_req && ((count_q != FULL) || pop);
      spurious = bus.bmu_valid_i && !pending_q;
      overflow = push_req && (count_q == FULL) && !pop;
   end
   // issue tracking, pointers, occupancy and sticky error; flush leaves the error flag alone
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
         tag_q     <= '0;
         error_q   <= 1'b0;
      end else begin
         error_q <= error_q | spurious | overflow;
         if (accept) tag_q <= bus.issue_tag_i;
         if (bus.flush_i) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
         end else begin
            pending_q <= accept | (pending_q & ~bus.bmu_valid_i);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
         end
      end
   end
   // entry storage written at the tail; contents are only meaningful behind count_q
   always_ff @(posedge clk_i) begin
      if (push && !bus.flush_i) begin
         res_mem[wr_ptr_q] <= bus.bmu_result_i;
         tag_mem[wr_ptr_q] <= tag_q;
      end
   end
   // head entry falls through to the writeback port
   always_comb begin
      bus.issue_ready_o = ready;
      bus.wb_valid_o    = count_q != '0;
      bus.wb_result_o   = res_mem[rd_ptr_q];
      bus.wb_tag_o      = tag_mem[rd_ptr_q];
      bus.count_o       = count_q;
      bus.error_o       = error_q;
   end
endmodule

// File: tb/tb_bmu_result_buffer.sv
// tb_bmu_result_buffer: directed and random stimulus against a queue-based reference model
module tb_bmu_result_buffer;
   localparam int DEPTH = 4;
   localparam int TW    = 6;
   logic clk_i   = 1'b0;
   logic rst_n_i = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   logic [37:0]   mq [$];
   logic          m_pend, m_err;
   logic [TW-1:0] m_tag;
   bmu_result_buffer_if #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) bus ();
   bmu_result_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .bus    (bus)
   );
   always #5 clk_i = ~clk_i;
   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask
   function automatic bit m_ready();
      return (mq.size() + int'(m_pend)) < DEPTH;
   endfunction
   task automatic model_reset();
      mq.delete();
      m_pend = 1'b0;
      m_err  = 1'b0;
      m_tag  = '0;
   endtask
   task automatic check_all();
      check("count", 64'(bus.count_o), 64'(mq.size()));
      check("wb_valid", 64'(bus.wb_valid_o), 64'(mq.size() != 0));
      check("issue_ready", 64'(bus.issue_ready_o), 64'(m_ready()));
      check("error", 64'(bus.error_o), 64'(m_err));
      if (mq.size() != 0) begin
         check("wb_tag", 64'(bus.wb_tag_o), 64'(mq[0][TW-1:0]));
         check("wb_result", 64'(bus.wb_result_o), 64'(mq[0][37:TW]));
      end
   endtask
   task automatic step(input bit iv, input logic [TW-1:0] tag, input bit bv, input logic [31:0] res,
                       input bit wr, input bit fl);
      bit acc, pop, fits;
      bus.issue_valid_i = iv;
      bus.issue_tag_i   = tag;
      bus.bmu_valid_i   = bv;
      bus.bmu_result_i  = res;
      bus.wb_ready_i    = wr;
      bus.flush_i       = fl;
      acc  = iv && m_ready();
      pop  = mq.size() != 0 && wr;
      fits = mq.size() < DEPTH || pop;
      if (bv && (!m_pend || !fits)) m_err = 1'b1;
      if (fl) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (bv && m_pend && fits) mq.push_back({res, m_tag});
      end
      if (acc) m_tag = tag;
      m_pend = fl ? 1'b0 : acc ? 1'b1 : bv ? 1'b0 : m_pend;
      @(posedge clk_i);
      #1;
      check_all();
   endtask
   task automatic idle(input bit wr);
      step(1'b0, '0, 1'b0, '0, wr, 1'b0);
   endtask
   initial begin
      bus.issue_valid_i = 1'b0;
      bus.issue_tag_i   = '0;
      bus.bmu_valid_i   = 1'b0;
      bus.bmu_result_i  = '0;
      bus.wb_ready_i    = 1'b0;
      bus.flush_i       = 1'b0;
      model_reset();
      #1;
      check_all();
      check("reset_ready", 64'(bus.issue_ready_o), 64'd1);
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      // single operation through the buffer
      step(1'b1, 6'd5, 1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0);
      check("single_valid", 64'(bus.wb_valid_o), 64'd1);
      check("single_tag", 64'(bus.wb_tag_o), 64'd5);
      check("single_data", 64'(bus.wb_result_o), 64'hFF);
      idle(1'b1);
      check("single_drained", 64'(bus.count_o), 64'd0);
      // fill with writeback stalled
      check("fill_ready1", 64'(bus.issue_ready_o), 64'd1);
      step(1'b1, 6'd1, 1'b0, '0, 1'b0, 1'b0);
      for (int t = 2; t <= 4; t++) begin
         check("fill_ready", 64'(bus.issue_ready_o), 64'd1);
         step(1'b1, TW'(t), 1'b1, 32'(t * 32'h11), 1'b0, 1'b0);
      end
      check("fill_not_ready", 64'(bus.issue_ready_o), 64'd0);
      check("fill_count3", 64'(bus.count_o), 64'd3);
      step(1'b0, '0, 1'b1, 32'h44, 1'b0, 1'b0);
      check("fill_count4", 64'(bus.count_o), 64'd4);
      check("fill_head_tag", 64'(bus.wb_tag_o), 64'd1);
      // stream from full with writeback open; pointers wrap repeatedly
      for (int i = 0; i < 12; i++)
         step(1'b1, TW'(10 + i), m_pend, $urandom, 1'b1, 1'b0);
      // flush with three entries and a pending op
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 6'd1, 1'b0, '0, 1'b0, 1'b0);
      for (int t = 2; t <= 4; t++) step(1'b1, TW'(t), 1'b1, 32'(t), 1'b0, 1'b0);
      check("preflush_count", 64'(bus.count_o), 64'd3);
      step(1'b0, '0, 1'b1, 32'hDEAD, 1'b0, 1'b1);
      check("flush_count", 64'(bus.count_o), 64'd0);
      check("flush_valid", 64'(bus.wb_valid_o), 64'd0);
      check("flush_ready", 64'(bus.issue_ready_o), 64'd1);
      idle(1'b0);
      check("flush_dropped", 64'(bus.count_o), 64'd0);
      // spurious result sets a sticky error
      step(1'b1, 6'd7, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 32'h77, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 32'hBAD, 1'b0, 1'b0);
      check("spurious_err", 64'(bus.error_o), 64'd1);
      check("spurious_count", 64'(bus.count_o), 64'd1);
      idle(1'b1);
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      check("err_sticky", 64'(bus.error_o), 64'd1);
      // asynchronous reset between edges with an op pending
      step(1'b1, 6'd8, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 6'd9, 1'b1, 32'h99, 1'b0, 1'b0);
      #3;
      rst_n_i = 1'b0;
      #1;
      model_reset();
      check_all();
      check("async_count", 64'(bus.count_o), 64'd0);
      check("async_err", 64'(bus.error_o), 64'd0);
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      step(1'b0, '0, 1'b1, 32'h55, 1'b0, 1'b0);
      check("post_reset_spurious", 64'(bus.error_o), 64'd1);
      check("post_reset_count", 64'(bus.count_o), 64'd0);
      // random traffic from a clean reset
      rst_n_i = 1'b0;
      #1;
      model_reset();
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      for (int i = 0; i < 500; i++)
         step($urandom_range(3) != 0, TW'($urandom), m_pend ? ($urandom_range(4) != 0) : ($urandom_range(63) == 0),
              $urandom, $urandom_range(2) != 0, $urandom_range(39) == 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bmu_result_buffer.md
BMU_RESULT_BUFFER -- requirements
Module: bmu_result_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the FIFO entry count; DEPTH is a power of two and at least 2.
REQ-002 The block SHALL have parameter TAG_WIDTH, default 6, giving the width of the destination/ROB tag.
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port issue_valid_i, input, 1 bit: an operation is driven into the bit manipulation unit this cycle.
REQ-006 The block SHALL have port issue_tag_i, input, TAG_WIDTH bits: tag of the issued operation.
REQ-007 The block SHALL have port issue_ready_o, output, 1 bit: the issue stage may issue a BMU operation this cycle.
REQ-008 The block SHALL have port bmu_result_i, input, 32 bits (data_word_t): BMU result.
REQ-009 The block SHALL have port bmu_valid_i, input, 1 bit: BMU result valid.
REQ-010 The block SHALL have port flush_i, input, 1 bit: pipeline flush.
REQ-011 The block SHALL have port wb_result_o, output, 32 bits: head entry result.
REQ-012 The block SHALL have port wb_tag_o, output, TAG_WIDTH bits: head entry tag.
REQ-013 The block SHALL have port wb_valid_o, output, 1 bit: head entry valid.
REQ-014 The block SHALL have port wb_ready_i, input, 1 bit: the writeback arbiter accepts the head entry.
REQ-015 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-016 The block SHALL have port error_o, output, 1 bit: sticky protocol error.

Function
REQ-017 An issue SHALL be accepted when issue_valid_i && issue_ready_o; acceptance registers issue_tag_i into tag_q and sets pending_q the next cycle.
REQ-018 pending_q SHALL clear on any cycle with bmu_valid_i=1 and no new accepted issue; if an accept and a bmu_valid_i coincide, pending_q SHALL stay 1 with tag_q updated (back-to-back issue).
REQ-019 BMU latency is exactly 1 cycle: bmu_valid_i=1 with pending_q=1 SHALL push {bmu_result_i, tag_q} into the FIFO tail.
REQ-020 bmu_valid_i=1 with pending_q=0 SHALL push nothing and set error_o, which then stays 1 until reset.
REQ-021 issue_ready_o SHALL be combinational from registers only and equal (count_q + pending_q) < DEPTH; it SHALL NOT depend on wb_ready_i.
REQ-022 The FIFO SHALL be first-word-fall-through: wb_valid_o = (count_q != 0), and wb_result_o/wb_tag_o SHALL show the head entry.
REQ-023 A pop SHALL occur when wb_valid_o && wb_ready_i; the read pointer advances modulo DEPTH.
REQ-024 On simultaneous push and pop, count_q SHALL be unchanged and both pointers SHALL advance, including when count_q == DEPTH.
REQ-025 A push when count_q == DEPTH without a pop SHALL be impossible by REQ-021; if it occurs anyway, the data SHALL be dropped and error_o set.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 with no bubble.
REQ-027 flush_i=1 SHALL, on the next edge, zero count_q, both pointers and pending_q; pushes and pops in the flush cycle SHALL be discarded; error_o SHALL be unaffected.
REQ-028 The output data in an empty FIFO SHALL be don't-care; only wb_valid_o qualifies it.

Reset
REQ-029 Reset SHALL act immediately and asynchronously when rst_n_i=0: count_q=0, pointers=0, pending_q=0, tag_q=0, error_o=0, wb_valid_o=0, issue_ready_o=1.
REQ-030 Reset asserted with an operation pending SHALL drop that operation; a bmu_valid_i on the first cycle after reset SHALL set error_o.
REQ-031 FIFO storage SHALL NOT require reset.

Verification
REQ-032 Single op: issue tag 5, result 0x0000_00FF one cycle later, wb_ready_i=1 -> wb_valid_o=1 with tag 5 and data 0xFF two cycles after issue, then count_o=0.
REQ-033 Fill: wb_ready_i=0, four back-to-back issues with tags 1..4 -> issue_ready_o=1 for the first three issues; after the fourth accept, issue_ready_o=0 and count_o reaches 4.
REQ-034 Stream at full: count_o=4, wb_ready_i=1 and one issue per cycle for 8 cycles -> count_o stays at 4, tags appear in order, and the pointers wrap twice.
REQ-035 Flush: count_o=3 plus one pending op, flush_i pulse -> next cycle count_o=0, wb_valid_o=0, issue_ready_o=1, and the pending result is not stored.
REQ-036 Spurious result: bmu_valid_i=1 with nothing pending -> count_o unchanged and error_o=1 until rst_n_i=0.
REQ-037 Async reset mid-stream: rst_n_i low between clock edges -> all outputs take their REQ-029 values before the next rising edge.
